// File: rtl/neuron_pkg.sv
// Shared types and default sizing for the neuron datapath blocks.
package neuron_pkg;

    localparam int DEFAULT_WEIGHT_WIDTH = 32;
    localparam int DEFAULT_INPUT_NUM    = 8;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DONE
    } state_t;

endpackage

// File: rtl/mac_unit.sv
// Signed multiply-accumulate: acc += sign-extended full-width a*b when enabled.
module mac_unit #(
    parameter int A_WIDTH   = 32,
    parameter int ACC_WIDTH = 67
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        enable,
    input  logic signed [A_WIDTH-1:0]   a,
    input  logic signed [A_WIDTH-1:0]   b,
    output logic signed [ACC_WIDTH-1:0] acc
);

    logic signed [2*A_WIDTH-1:0] w_product;
    logic signed [ACC_WIDTH-1:0] w_product_ext;
    logic signed [ACC_WIDTH-1:0] r_acc;

    // Widen both operands first so the product keeps all 2*A_WIDTH bits.
    assign w_product     = (2*A_WIDTH)'(a) * (2*A_WIDTH)'(b);
    assign w_product_ext = ACC_WIDTH'(w_product);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (clear) begin
            r_acc <= '0;
        end else if (enable) begin
            r_acc <= r_acc + w_product_ext;
        end
    end

    assign acc = r_acc;

endmodule

// File: rtl/weight_fetch_mac.sv
// Neuron dot-product engine: streams inputs against weights fetched by index,
// then holds the signed sum until the consumer takes it.
module weight_fetch_mac
    import neuron_pkg::*;
#(
    parameter int WEIGHT_WIDTH = DEFAULT_WEIGHT_WIDTH,
    parameter int INPUT_NUM    = DEFAULT_INPUT_NUM,
    parameter int ADDR_WIDTH   = $clog2(INPUT_NUM),
    parameter int ACC_WIDTH    = 2*WEIGHT_WIDTH + $clog2(INPUT_NUM)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    output logic                           busy,
    output logic                           read_enable,
    output logic [ADDR_WIDTH-1:0]          read_address,
    input  logic signed [WEIGHT_WIDTH-1:0] read_data,
    input  logic                           in_valid,
    input  logic signed [WEIGHT_WIDTH-1:0] in_data,
    output logic                           in_ready,
    output logic                           out_valid,
    output logic signed [ACC_WIDTH-1:0]    out_data,
    input  logic                           out_ready
);

    localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = ADDR_WIDTH'(INPUT_NUM - 1);

    state_t                       r_state;
    logic [ADDR_WIDTH-1:0]        r_index;
    logic                         r_busy;
    logic                         r_out_valid;
    logic                         w_clear;
    logic                         w_enable;
    logic signed [ACC_WIDTH-1:0]  w_acc;

    assign w_clear  = (r_state == IDLE) && start;
    assign w_enable = r_busy && in_valid;

    // The index is parked at 0 outside FETCH so read_address needs no gating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_index     <= '0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= FETCH;
                        r_index <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                FETCH: begin
                    if (in_valid) begin
                        if (r_index == LAST_INDEX) begin
                            r_state     <= DONE;
                            r_index     <= '0;
                            r_busy      <= 1'b0;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_index <= r_index + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_index     <= '0;
                    r_busy      <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    mac_unit #(
        .A_WIDTH  (WEIGHT_WIDTH),
        .ACC_WIDTH(ACC_WIDTH)
    ) u_mac (
        .clk   (clk),
        .rst   (rst),
        .clear (w_clear),
        .enable(w_enable),
        .a     (in_data),
        .b     (read_data),
        .acc   (w_acc)
    );

    assign busy         = r_busy;
    assign read_enable  = r_busy;
    assign in_ready     = r_busy;
    assign read_address = r_index;
    assign out_valid    = r_out_valid;
    assign out_data     = r_out_valid ? w_acc : '0;

endmodule

// File: tb/tb_weight_fetch_mac.sv
// Directed bench for weight_fetch_mac at WEIGHT_WIDTH=8, INPUT_NUM=4 with a
// combinational weight memory.
module tb_weight_fetch_mac;

    localparam int WW   = 8;
    localparam int NUM  = 4;
    localparam int AW   = 2;
    localparam int ACCW = 18;

    logic                   clk;
    logic                   rst;
    logic                   start;
    logic                   busy;
    logic                   readEnable;
    logic [AW-1:0]          readAddress;
    logic signed [WW-1:0]   readData;
    logic                   inValid;
    logic signed [WW-1:0]   inData;
    logic                   inReady;
    logic                   outValid;
    logic signed [ACCW-1:0] outData;
    logic                   outReady;

    logic [WW-1:0] memW [NUM];

    int nChecks;
    int nFails;

    typedef struct {
        logic [3:0][7:0] w;
        logic [3:0][7:0] x;
        longint          expResult;
        int              expEdges;
    } vec_t;

    vec_t vecs [5];

    weight_fetch_mac #(
        .WEIGHT_WIDTH(WW),
        .INPUT_NUM   (NUM)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .read_enable (readEnable),
        .read_address(readAddress),
        .read_data   (readData),
        .in_valid    (inValid),
        .in_data     (inData),
        .in_ready    (inReady),
        .out_valid   (outValid),
        .out_data    (outData),
        .out_ready   (outReady)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory returns the addressed weight in the same cycle.
    always_comb readData = memW[readAddress];

    function automatic logic [3:0][7:0] pack4(input int a, input int b, input int c, input int d);
        logic [3:0][7:0] p;
        p[0] = 8'(a);
        p[1] = 8'(b);
        p[2] = 8'(c);
        p[3] = 8'(d);
        return p;
    endfunction

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Runs one evaluation; stalls in_valid for stallLen cycles while index==stallAt.
    // Returns at the negedge where out_valid is first seen (or on timeout).
    task automatic applyStimulus(input logic [3:0][7:0] w, input logic [3:0][7:0] x,
                                 input int stallAt, input int stallLen, input logic readyVal,
                                 output longint result, output int edges);
        int  k;
        int  stalled;
        bit  accepted;
        bit  seen;
        for (int i = 0; i < NUM; i++) memW[i] = w[i];
        k       = 0;
        stalled = 0;
        seen    = 0;
        result  = 0;
        @(negedge clk);
        outReady = readyVal;
        start    = 1'b1;
        @(posedge clk);
        edges = 1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (outValid) begin
                seen = 1;
                break;
            end
            checkOutput("busy in FETCH", longint'(busy), 1);
            checkOutput("read_address in FETCH", longint'(readAddress), longint'(k));
            if (k == stallAt && stalled < stallLen) begin
                inValid = 1'b0;
                inData  = 8'sh55;
                stalled++;
            end else begin
                inValid = 1'b1;
                inData  = $signed(x[k < NUM ? k : 0]);
            end
            accepted = inValid && inReady;
            @(posedge clk);
            edges++;
            if (accepted) k++;
        end
        if (!seen) begin
            checkOutput("out_valid timeout", 0, 1);
        end else begin
            result = longint'($signed(outData));
        end
        inValid = 1'b0;
    endtask

    initial begin
        longint res;
        int     edges;
        longint held;

        nChecks  = 0;
        nFails   = 0;
        start    = 1'b0;
        inValid  = 1'b0;
        inData   = '0;
        outReady = 1'b1;
        for (int i = 0; i < NUM; i++) memW[i] = '0;

        vecs[0] = '{w: pack4(1, 2, 3, 4),         x: pack4(1, 1, 1, 1),             expResult: 10,     expEdges: 5};
        vecs[1] = '{w: pack4(-1, 2, -3, 4),       x: pack4(5, -6, 7, 8),            expResult: -6,     expEdges: 5};
        vecs[2] = '{w: pack4(127, 127, 127, 127), x: pack4(-128, -128, -128, -128), expResult: -65024, expEdges: 5};
        vecs[3] = '{w: pack4(-128, -128, -128, -128), x: pack4(-128, -128, -128, -128), expResult: 65536, expEdges: 5};
        vecs[4] = '{w: pack4(3, -7, 0, 100),      x: pack4(-2, -5, 9, 1),           expResult: 129,    expEdges: 5};

        rst = 1'b1;
        #12;
        checkOutput("reset busy", longint'(busy), 0);
        checkOutput("reset out_valid", longint'(outValid), 0);
        checkOutput("reset read_address", longint'(readAddress), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle without start", longint'(busy), 0);

        for (int v = 0; v < 5; v++) begin
            applyStimulus(vecs[v].w, vecs[v].x, -1, 0, 1'b1, res, edges);
            checkOutput($sformatf("vec%0d out_data", v), res, vecs[v].expResult);
            checkOutput($sformatf("vec%0d latency", v), longint'(edges), longint'(vecs[v].expEdges));
            checkOutput($sformatf("vec%0d read_enable in DONE", v), longint'(readEnable), 0);
            @(negedge clk);
            checkOutput($sformatf("vec%0d out_valid one cycle", v), longint'(outValid), 0);
            checkOutput($sformatf("vec%0d out_data cleared", v), longint'($signed(outData)), 0);
        end

        // Stall three cycles at index 1: 4+6+6+4 = 20, latency 5+3.
        applyStimulus(pack4(1, 2, 3, 4), pack4(4, 3, 2, 1), 1, 3, 1'b1, res, edges);
        checkOutput("stall out_data", res, 20);
        checkOutput("stall latency", longint'(edges), 8);
        @(negedge clk);

        // Hold result in DONE with out_ready low while start pulses.
        applyStimulus(pack4(1, 2, 3, 4), pack4(2, 2, 2, 2), -1, 0, 1'b0, res, edges);
        checkOutput("hold out_data", res, 20);
        held = res;
        for (int c = 0; c < 4; c++) begin
            start = (c == 1);
            @(negedge clk);
            start = 1'b0;
            checkOutput("hold out_valid", longint'(outValid), 1);
            checkOutput("hold out_data stable", longint'($signed(outData)), held);
            checkOutput("hold busy", longint'(busy), 0);
        end
        outReady = 1'b1;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("release out_valid", longint'(outValid), 0);
        checkOutput("release start ignored", longint'(busy), 0);
        @(negedge clk);
        checkOutput("release stays idle", longint'(busy), 0);

        // Reset in the middle of FETCH at index 2, between clock edges.
        for (int i = 0; i < NUM; i++) memW[i] = 8'd3;
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        inValid = 1'b1;
        inData  = 8'sd5;
        @(negedge clk);
        @(negedge clk);
        checkOutput("pre-reset read_address", longint'(readAddress), 2);
        #2 rst = 1'b1;
        #1;
        checkOutput("async reset busy", longint'(busy), 0);
        checkOutput("async reset read_enable", longint'(readEnable), 0);
        checkOutput("async reset in_ready", longint'(inReady), 0);
        checkOutput("async reset read_address", longint'(readAddress), 0);
        checkOutput("async reset out_valid", longint'(outValid), 0);
        checkOutput("async reset out_data", longint'($signed(outData)), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post-reset needs start", longint'(busy), 0);
        inValid = 1'b0;
        applyStimulus(pack4(1, 1, 1, 1), pack4(2, 2, 2, 2), -1, 0, 1'b1, res, edges);
        checkOutput("post-reset out_data", res, 8);
        checkOutput("post-reset latency", longint'(edges), 5);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/weight_fetch_mac.md
WEIGHT_FETCH_MAC -- requirements
Module: weight_fetch_mac

Interface
REQ-001 Parameter WEIGHT_WIDTH, default 32: signed weight and input-sample width in bits.
REQ-002 Parameter INPUT_NUM, default 8: number of weights and inputs per neuron evaluation, minimum 2.
REQ-003 Parameter ADDR_WIDTH, default $clog2(INPUT_NUM): weight-memory address width.
REQ-004 Parameter ACC_WIDTH, default 2*WEIGHT_WIDTH+$clog2(INPUT_NUM): accumulator and result width.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  single-cycle request to begin one dot-product evaluation.
REQ-008 busy  output  1  high while an evaluation is in progress (FETCH state).
REQ-009 read_enable  output  1  weight-memory read strobe.
REQ-010 read_address  output  ADDR_WIDTH  weight index being read.
REQ-011 read_data  input  WEIGHT_WIDTH  weight returned combinationally by memory in the same cycle.
REQ-012 in_valid  input  1  input sample available.
REQ-013 in_data  input  WEIGHT_WIDTH  signed input sample, presented in index order 0..INPUT_NUM-1.
REQ-014 in_ready  output  1  block will consume in_data at this edge.
REQ-015 out_valid  output  1  result available.
REQ-016 out_data  output  ACC_WIDTH  signed dot product of inputs and weights.
REQ-017 out_ready  input  1  consumer accepts result.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, FETCH, DONE.
REQ-019 In IDLE, start=1 at a rising edge SHALL clear the accumulator, set the index to 0 and move to FETCH; otherwise IDLE is held.
REQ-020 In FETCH, read_enable SHALL be 1, read_address SHALL equal the current index, and in_ready SHALL be 1.
REQ-021 In FETCH, an edge with in_valid=1 SHALL add sign-extended (in_data * read_data), a full 2*WEIGHT_WIDTH signed product, to the accumulator and increment the index.
REQ-022 In FETCH, in_valid=0 SHALL stall: index, address and accumulator unchanged, no timeout.
REQ-023 The edge consuming index INPUT_NUM-1 SHALL move to DONE with the final sum; the index SHALL not wrap or exceed INPUT_NUM-1.
REQ-024 With in_valid held high, out_valid SHALL rise exactly INPUT_NUM+1 rising edges after the edge accepting start.
REQ-025 Accumulation SHALL be two's-complement modulo 2^ACC_WIDTH (no saturation).
REQ-026 In DONE, out_valid=1 and out_data SHALL hold the result stable until an edge with out_ready=1, which returns the FSM to IDLE.
REQ-027 start SHALL be ignored in FETCH and DONE; start and out_ready on the same edge in DONE SHALL return to IDLE without starting a new evaluation.
REQ-028 Outside FETCH, read_enable, in_ready and busy SHALL be 0, and read_address SHALL be 0.
REQ-029 out_data SHALL be 0 whenever out_valid=0.

Reset
REQ-030 rst=1 SHALL immediately, regardless of clk, force IDLE, accumulator and index 0, and drive busy, read_enable, in_ready, out_valid to 0 and read_address, out_data to 0.
REQ-031 Reset asserted mid-FETCH or mid-DONE SHALL discard the partial or pending result; the first evaluation after reset release requires a fresh start.

Structure
REQ-032 A shared package neuron_pkg SHALL hold the state typedef (IDLE/FETCH/DONE) and the default WEIGHT_WIDTH/INPUT_NUM constants.
REQ-033 The multiply-accumulate datapath SHALL be one sub-module, mac_unit (clear, enable, a, b -> acc), instantiated once.

Verification (INPUT_NUM=4, WEIGHT_WIDTH=8, memory model returning read_data combinationally)
REQ-034 Weights {1,2,3,4}, inputs {1,1,1,1}, in_valid held high, out_ready high -> out_data=10, out_valid for one cycle, 5 edges after start.
REQ-035 Weights {-1,2,-3,4}, inputs {5,-6,7,8} -> out_data=-5-12-21+32=-6, sign-extended to ACC_WIDTH.
REQ-036 Weights {127,127,127,127}, inputs {-128,-128,-128,-128} -> out_data=-65024 with no wrap.
REQ-037 in_valid low for 3 cycles after index 1 -> read_address stays 1, accumulator unchanged, final result correct, out_valid delayed by 3 cycles.
REQ-038 out_ready low 4 cycles in DONE, start pulsed meanwhile -> out_data stable, start ignored, IDLE after out_ready=1.
REQ-039 rst asserted at index 2 between clock edges -> outputs 0 immediately; the next start with weights {1,1,1,1} and inputs {2,2,2,2} yields 8.
